fu_arbiter: RTL and testbench
=============================

FU_ARBITER -- requirements
Module: fu_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of requesters sharing one multi-cycle functional unit (sqrt/FP); range 2..8.
REQ-002 Parameter WIDTH, default 32, operand/result width in bits.
REQ-003 Parameter TIMEOUT, default 64, WAIT-state cycle limit; used only under FU_ARB_TIMEOUT_EN.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port req_valid  input  NREQ  per-requester operation request.
REQ-007 Port req_operand  input  NREQ*WIDTH  packed operands; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port req_ready  output  NREQ  one-hot acceptance; transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-009 Port resp_valid  output  NREQ  one-hot, one-cycle result strobe to the granted requester.
REQ-010 Port resp_result  output  WIDTH  result; valid only while any resp_valid bit is high.
REQ-011 Port resp_err  output  1  timeout flag, qualified by resp_valid.
REQ-012 Port unit_start  output  1  one-cycle start pulse to the functional unit.
REQ-013 Port unit_operand  output  WIDTH  operand to the unit; held stable from ISSUE until the next accept.
REQ-014 Port unit_done  input  1  one-cycle completion pulse from the unit.
REQ-015 Port unit_result  input  WIDTH  unit result, sampled when unit_done is high.
REQ-016 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-018 IDLE: if any req_valid is high, assert req_ready for exactly one requester chosen round-robin starting at rr_ptr; latch its operand and index; go to ISSUE.
REQ-019 req_ready SHALL be combinational from state, req_valid and rr_ptr, and SHALL be zero outside IDLE.
REQ-020 ISSUE: assert unit_start for exactly one cycle with unit_operand equal to the latched operand; go to WAIT.
REQ-021 WAIT: on unit_done, latch unit_result and go to RESP; unit_done in IDLE, ISSUE or RESP SHALL be ignored.
REQ-022 RESP: assert resp_valid[granted] for one cycle with registered resp_result; set rr_ptr to (granted+1) mod NREQ; go to IDLE.
REQ-023 Minimum request-to-response latency SHALL be 3 cycles plus unit latency; back-to-back accepts SHALL be separated by at least 4 cycles.
REQ-024 Simultaneous requests SHALL be granted in rotation, with no requester starved across NREQ consecutive grants.
REQ-025 Deasserting req_valid without a handshake SHALL cancel that request with no side effect.

Reset
REQ-026 While reset is high at a clock edge: state <= IDLE, rr_ptr <= 0, latched operand/result/index <= 0, timeout counter <= 0.
REQ-027 After reset, all outputs SHALL be 0: req_ready, resp_valid, resp_result, resp_err, unit_start, unit_operand and busy.
REQ-028 Reset mid-operation SHALL abandon the in-flight operation with no response, and a later stale unit_done SHALL be ignored.

Configuration
REQ-029 With FU_ARB_TIMEOUT_EN defined: a counter runs in WAIT; if TIMEOUT cycles elapse without unit_done, go to RESP with resp_err=1 and resp_result=0.
REQ-030 Without FU_ARB_TIMEOUT_EN: no counter is built, resp_err is tied to 0, and WAIT is held indefinitely.

Structure
REQ-031 Shared package cpu_fu_pkg SHALL hold the FSM state enum typedef and the default WIDTH/NREQ/TIMEOUT constants.
REQ-032 Round-robin selection SHALL be a separate sub-module rr_arbiter, with inputs request vector and pointer and a one-hot grant output.

Verification
REQ-033 Single request: req_valid=01, operand 0x00000010, unit returns 0x4 after 5 cycles -> unit_start 1 cycle, resp_valid=01, resp_result=0x4, resp_err=0.
REQ-034 Contention: req_valid=11 held for 3 ops with rr_ptr=0 -> grant order 0,1,0; each resp_valid goes to the matching requester.
REQ-035 Stray done: unit_done pulsed in IDLE and in ISSUE -> no state change and no resp_valid.
REQ-036 Reset mid-WAIT: reset asserted for 1 cycle, then unit_done -> busy=0, no resp_valid, rr_ptr=0.
REQ-037 Timeout (FU_ARB_TIMEOUT_EN, TIMEOUT=8): unit_done never asserted -> resp_valid after 8 WAIT cycles with resp_err=1 and resp_result=0.
REQ-038 Without the macro, same stimulus as REQ-037 -> busy stays 1 for 100 cycles and resp_err stays 0.

Source files
------------

// File: rtl/cpu_fu_pkg.sv
// Shared FSM state type and default sizing for the functional-unit arbiter.
package cpu_fu_pkg;

    localparam int DEF_NREQ    = 2;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } fu_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: one-hot grant to the first active request at or after ptr.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant
);

    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return (v >= NREQ) ? IDX_W'(v - NREQ) : IDX_W'(v);
    endfunction

    // Scan from lowest priority to highest so the last hit (closest to ptr) wins.
    always_comb begin
        // NOTE: default assignment first keeps this block free of inferred latches.
        grant = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            if (req[wrap_idx(int'(ptr) + off)]) begin
                grant = '0;
                grant[wrap_idx(int'(ptr) + off)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fu_arbiter.sv
// Shares one multi-cycle functional unit among NREQ requesters (IDLE/ISSUE/WAIT/RESP).
// Define FU_ARB_TIMEOUT_EN to add a WAIT-state watchdog that returns resp_err.
module fu_arbiter
    import cpu_fu_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_operand,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]      resp_result,
    output logic                  resp_err,
    output logic                  unit_start,
    output logic [WIDTH-1:0]      unit_operand,
    input  logic                  unit_done,
    input  logic [WIDTH-1:0]      unit_result,
    output logic                  busy
);

    localparam int IDX_W = $clog2(NREQ);

    fu_state_e        state_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] grant_idx;
    logic [NREQ-1:0]  grant;
    logic [WIDTH-1:0] sel_operand;
    logic [WIDTH-1:0] operand_q;
    logic [WIDTH-1:0] result_q;
    logic [NREQ-1:0]  resp_valid_q;
    logic             unit_start_q;

`ifdef FU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_q;
    logic             err_q;
    assign resp_err = err_q;
`else
    localparam int unused_timeout = TIMEOUT;
    assign resp_err = 1'b0;
`endif

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    always_comb begin
        grant_idx   = '0;
        sel_operand = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx   = IDX_W'(i);
                sel_operand = req_operand[i*WIDTH +: WIDTH];
            end
        end
    end

    assign rr_ptr_d = (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            idx_q        <= '0;
            operand_q    <= '0;
            result_q     <= '0;
            resp_valid_q <= '0;
            unit_start_q <= 1'b0;
`ifdef FU_ARB_TIMEOUT_EN
            tmo_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            unit_start_q <= 1'b0;
            resp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        operand_q    <= sel_operand;
                        idx_q        <= grant_idx;
                        unit_start_q <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
`ifdef FU_ARB_TIMEOUT_EN
                    tmo_q   <= '0;
`endif
                end
                WAIT: begin
                    if (unit_done) begin
                        result_q     <= unit_result;
                        resp_valid_q <= NREQ'(1) << idx_q;
                        state_q      <= RESP;
`ifdef FU_ARB_TIMEOUT_EN
                        err_q        <= 1'b0;
                    end else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
                        result_q     <= '0;
                        err_q        <= 1'b1;
                        resp_valid_q <= NREQ'(1) << idx_q;
                        state_q      <= RESP;
                    end else begin
                        tmo_q        <= tmo_q + 1'b1;
`endif
                    end
                end
                RESP: begin
                    rr_ptr_q <= rr_ptr_d;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready    = (state_q == IDLE) ? grant : '0;
    assign resp_valid   = resp_valid_q;
    assign resp_result  = result_q;
    assign unit_start   = unit_start_q;
    assign unit_operand = operand_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_fu_arbiter.sv
// Directed scoreboard bench for fu_arbiter (NREQ=2, WIDTH=32, TIMEOUT=8).
module tb_fu_arbiter;

    localparam int NREQ    = 2;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 8;

    typedef struct {
        int          idx;
        logic [31:0] result;
        logic        err;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_operand;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       resp_valid;
    logic [WIDTH-1:0]      resp_result;
    logic                  resp_err;
    logic                  unit_start;
    logic [WIDTH-1:0]      unit_operand;
    logic                  unit_done;
    logic [WIDTH-1:0]      unit_result;
    logic                  busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    exp_t mon_e;

    fu_arbiter #(
        .NREQ    (NREQ),
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_operand  (req_operand),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_result  (resp_result),
        .resp_err     (resp_err),
        .unit_start   (unit_start),
        .unit_operand (unit_operand),
        .unit_done    (unit_done),
        .unit_result  (unit_result),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every resp_valid strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (resp_valid !== '0) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 64'(resp_valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_resp_valid", 64'(resp_valid), 64'(2'b01 << mon_e.idx));
                check("sb_resp_result", 64'(resp_result), 64'(mon_e.result));
                check("sb_resp_err", 64'(resp_err), 64'(mon_e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '0;
        unit_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One complete transaction; unit_done arrives lat cycles after the ISSUE cycle.
    task automatic do_op(input logic [1:0] valid, input logic [31:0] op0, input logic [31:0] op1,
                         input int exp_idx, input int lat, input logic [31:0] res,
                         input bit hold, input bit stray);
        logic [31:0] exp_op;
        exp_op = (exp_idx == 0) ? op0 : op1;
        @(negedge clk);
        req_valid   = valid;
        req_operand = {op1, op0};
        #1;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_req_ready", 64'(req_ready), 64'(2'b01 << exp_idx));
        sb.push_back('{exp_idx, res, 1'b0});
        @(negedge clk);
        if (!hold) req_valid = '0;
        check("issue_start", 64'(unit_start), 64'd1);
        check("issue_operand", 64'(unit_operand), 64'(exp_op));
        check("issue_ready_zero", 64'(req_ready), 64'd0);
        if (stray) begin
            unit_done   = 1'b1;
            unit_result = 32'hDEAD_BEEF;
        end
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            unit_done = 1'b0;
            if (c == 1) begin
                check("wait_start_low", 64'(unit_start), 64'd0);
                check("wait_busy", 64'(busy), 64'd1);
                check("wait_no_resp", 64'(resp_valid), 64'd0);
            end
        end
        unit_done   = 1'b1;
        unit_result = res;
        @(negedge clk);
        unit_done = 1'b0;
        check("resp_strobe", 64'(resp_valid), 64'(2'b01 << exp_idx));
    endtask

    initial begin
        int bad;
        reset       = 1'b1;
        req_valid   = '0;
        req_operand = '0;
        unit_done   = 1'b0;
        unit_result = '0;

        do_reset();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_result", 64'(resp_result), 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_unit_start", 64'(unit_start), 64'd0);
        check("rst_unit_operand", 64'(unit_operand), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // Single request, unit latency 5.
        do_op(2'b01, 32'h0000_0010, 32'h0, 0, 5, 32'h4, 1'b0, 1'b0);

        // Contention from rr_ptr=0: grants 0,1,0.
        do_reset();
        do_op(2'b11, 32'h0000_00A0, 32'h0000_00B1, 0, 3, 32'h100, 1'b1, 1'b0);
        do_op(2'b11, 32'h0000_00A0, 32'h0000_00B1, 1, 2, 32'h101, 1'b1, 1'b0);
        do_op(2'b11, 32'h0000_00A0, 32'h0000_00B1, 0, 1, 32'h102, 1'b0, 1'b0);

        // Stray done in IDLE, then in ISSUE.
        @(negedge clk);
        unit_done   = 1'b1;
        unit_result = 32'hBAD0_0001;
        @(negedge clk);
        unit_done = 1'b0;
        check("stray_idle_busy", 64'(busy), 64'd0);
        check("stray_idle_resp", 64'(resp_valid), 64'd0);
        do_op(2'b01, 32'h0000_0033, 32'h0, 0, 3, 32'h0000_0123, 1'b0, 1'b1);

`ifdef FU_ARB_TIMEOUT_EN
        // Watchdog: RESP follows exactly TIMEOUT WAIT cycles.
        @(negedge clk);
        req_valid   = 2'b01;
        req_operand = {32'h0, 32'h0000_0055};
        sb.push_back('{0, 32'h0, 1'b1});
        @(negedge clk);
        req_valid = '0;
        check("tmo_issue_start", 64'(unit_start), 64'd1);
        repeat (TIMEOUT) @(negedge clk);
        check("tmo_not_early", 64'(resp_valid), 64'd0);
        check("tmo_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("tmo_resp_valid", 64'(resp_valid), 64'd1);
        check("tmo_resp_err", 64'(resp_err), 64'd1);
        check("tmo_resp_result", 64'(resp_result), 64'd0);
`else
        // No watchdog: WAIT holds indefinitely.
        @(negedge clk);
        req_valid   = 2'b01;
        req_operand = {32'h0, 32'h0000_0055};
        @(negedge clk);
        req_valid = '0;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (busy !== 1'b1 || resp_err !== 1'b0 || resp_valid !== '0) bad++;
        end
        check("no_tmo_hold", 64'(bad), 64'd0);
        do_reset();
`endif

        // Reset mid-WAIT abandons the operation; a stale done is ignored.
        @(negedge clk);
        req_valid   = 2'b10;
        req_operand = {32'h0000_0077, 32'h0};
        @(negedge clk);
        req_valid = '0;
        check("rw_issue_start", 64'(unit_start), 64'd1);
        @(negedge clk);
        check("rw_wait_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rw_busy", 64'(busy), 64'd0);
        check("rw_operand", 64'(unit_operand), 64'd0);
        check("rw_resp", 64'(resp_valid), 64'd0);
        unit_done   = 1'b1;
        unit_result = 32'hBAD0_0002;
        @(negedge clk);
        unit_done = 1'b0;
        check("rw_stale_busy", 64'(busy), 64'd0);
        req_valid = 2'b11;
        #1;
        check("rw_rr_ptr_zero", 64'(req_ready), 64'd1);
        req_valid = '0;
        repeat (3) @(negedge clk);
        check("rw_stale_no_resp", 64'(resp_valid), 64'd0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
